uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200 baud); legal range >= 8.
REQ-002 The module SHALL have parameter HALF_BIT, default CLKS_PER_BIT/2 (integer division), giving the start-bit mid-point sample offset.
REQ-003 The module SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-004 The module SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port: rx  input  1  asynchronous serial line; idles high; 8N1 frames, LSB first.
REQ-006 The module SHALL have port: d_in  output  8  last correctly received byte.
REQ-007 The module SHALL have port: done  output  1  d_in holds a byte not yet acknowledged.
REQ-008 The module SHALL have port: ack  input  1  consumer acknowledge; clears done.
REQ-009 The module SHALL have port: frame_err  output  1  sticky; the stop bit of a frame sampled low.
REQ-010 The module SHALL have port: overrun  output  1  sticky; a good byte arrived while done was high and not being acked.
REQ-011 The module SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-012 The module SHALL pass rx through a 2-flop synchronizer (rx_s); no other logic uses rx directly.
REQ-013 The module SHALL implement the states IDLE, START, DATA, STOP and BREAK, plus a bit counter (cnt) and a bit index (bit_idx, 0-7).
REQ-014 In IDLE, when rx_s==0 the module SHALL go to START with cnt<=0.
REQ-015 In START, cnt SHALL increment each cycle; at cnt==HALF_BIT-1: if rx_s==0, go to DATA with cnt<=0 and bit_idx<=0; else (glitch) return to IDLE with no output change.
REQ-016 In DATA, at cnt==CLKS_PER_BIT-1 the module SHALL store rx_s into shift bit bit_idx and set cnt<=0; after bit_idx==7 go to STOP, else bit_idx+1.
REQ-017 In STOP, at cnt==CLKS_PER_BIT-1 with rx_s==1 (good frame), the module SHALL go to IDLE.
REQ-018 On a good frame with done==0, or with done==1 and ack==1 in the same cycle: d_in<=shifted byte, done<=1, frame_err<=0.
REQ-019 On a good frame with done==1 and ack==0: d_in and done SHALL be unchanged (new byte dropped) and overrun<=1.
REQ-020 In STOP, at cnt==CLKS_PER_BIT-1 with rx_s==0, the module SHALL set frame_err<=1, leave d_in and done unchanged, and go to BREAK.
REQ-021 In BREAK, the module SHALL remain until rx_s==1, then go to IDLE; a line held low SHALL NOT produce repeated frames.
REQ-022 ack==1 while done==1 SHALL clear done, overrun and frame_err next cycle, unless REQ-018 sets done in that same cycle.
REQ-023 ack while done==0 SHALL have no effect.
REQ-024 Latency: if rx is first low at rising edge k, the stop-bit sample SHALL occur at edge k+2+HALF_BIT+9*CLKS_PER_BIT, and done (good frame) SHALL be high from that edge on.
REQ-025 Back-to-back frames SHALL be accepted: a start bit beginning immediately after the stop-bit sample SHALL be detected without loss.
REQ-026 cnt width SHALL be clog2(CLKS_PER_BIT), and cnt SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-027 While rst==1 at a clk edge, the module SHALL set state=IDLE, cnt=0, bit_idx=0, d_in=8'h00, done=0, frame_err=0, overrun=0, busy=0, and both synchronizer flops=1.
REQ-028 rst asserted mid-frame SHALL abort the frame with no output update.
REQ-029 After rst deasserts mid-frame, the module SHALL NOT detect a new start until rx_s has been low after IDLE entry.

Verification
REQ-030 Bench: CLKS_PER_BIT=16; send 8'h68 ("h"), rx first low at edge k -> done high at edge k+154, d_in=8'h68, frame_err=0, busy low the same edge.
REQ-031 Bench: send "hello" back-to-back with ack pulsed 1 cycle after each done -> d_in sequence 68,65,6C,6C,6F, overrun never set.
REQ-032 Bench: send 8'h41, no ack, then send 8'h42 -> d_in stays 8'h41, overrun=1; ack then clears done and overrun.
REQ-033 Bench: send 8'h55 with stop bit forced 0, rx held low 40 cycles then high -> frame_err=1, done=0, no further frame, then IDLE.
REQ-034 Bench: 4-cycle low glitch on rx in IDLE -> return to IDLE after START, no done or frame_err.
REQ-035 Bench: assert rst during DATA bit 3 -> all outputs at reset values next edge; next full frame 8'hA5 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, a single-byte holding
// register with done/ack handshake, sticky frame-error and overrun flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] d_in,
  output logic       done,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sync_reg;
  logic            rx_s;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      d_in_reg, d_in_next;
  logic            done_reg, done_next;
  logic            frame_err_reg, frame_err_next;
  logic            overrun_reg, overrun_next;

  // Synchronizer resets to the idle (high) level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      d_in_reg      <= 8'h00;
      done_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      d_in_reg      <= d_in_next;
      done_reg      <= done_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    d_in_next      = d_in_reg;
    done_next      = done_reg;
    frame_err_next = frame_err_reg;
    overrun_next   = overrun_reg;

    // Acknowledge clears first; frame events below may set flags again in the same cycle.
    if (ack && done_reg) begin
      done_next      = 1'b0;
      overrun_next   = 1'b0;
      frame_err_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next                = '0;
          shift_next[bit_idx_reg] = rx_s;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = IDLE;
            if (!done_reg || ack) begin
              d_in_next      = shift_reg;
              done_next      = 1'b1;
              frame_err_next = 1'b0;
            end else begin
              overrun_next = 1'b1;
            end
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign d_in      = d_in_reg;
  assign done      = done_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a byte-level model of the receiver's
// handshake rules; comparisons are immediate assertions.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] d_in;
  logic       done, frame_err, overrun, busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .d_in(d_in), .done(done), .ack(ack),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: records every rising edge of done and whether overrun was ever seen.
  int         done_rise = -1;
  int         rises = 0;
  logic       busy_at_rise = 1'b0;
  logic       done_q = 1'b0;
  logic       ovr_seen = 1'b0;
  logic [7:0] got_q[$];
  always @(posedge clk) begin
    #1;
    if (done === 1'b1 && done_q !== 1'b1) begin
      done_rise    = cyc;
      rises++;
      busy_at_rise = busy;
      got_q.push_back(d_in);
    end
    done_q = done;
    if (overrun === 1'b1) ovr_seen = 1'b1;
  end

  // Optional consumer that acks one cycle after each done.
  logic auto_ack = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_ack && done === 1'b1 && !ack) begin
        @(negedge clk) ack = 1'b1;
        @(negedge clk) ack = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  // Reference model: what the consumer should see, by byte-level rules.
  logic [7:0] exp_d = 8'h00;
  logic       exp_done = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) exp_ferr = 1'b1;
    else if (exp_done) exp_ovr = 1'b1;
    else begin
      exp_d = b; exp_done = 1'b1; exp_ferr = 1'b0;
    end
  endtask

  task automatic model_ack();
    if (exp_done) begin
      exp_done = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_d_in"}, {24'h0, d_in}, {24'h0, exp_d});
    check({tag, "_done"}, {31'h0, done}, {31'h0, exp_done});
    check({tag, "_ferr"}, {31'h0, frame_err}, {31'h0, exp_ferr});
    check({tag, "_ovr"}, {31'h0, overrun}, {31'h0, exp_ovr});
    $display("[TB] %s: d_in=%02h done=%0b frame_err=%0b overrun=%0b", tag, d_in, done, frame_err, overrun);
  endtask

  // Called at a negedge; each bit is held for CPB cycles, rx left at the stop level.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    model_ack();
  endtask

  logic [7:0] hello [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

  initial begin
    int k, r0;
    logic [7:0] b;
    logic err;
    logic [7:0] a5;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check_model("reset");
    rst = 1'b0;
    idle(5);

    // Single byte with exact latency
    k = cyc + 1;
    r0 = rises;
    send_byte(8'h68, 1'b1);
    model_frame(8'h68, 1'b1);
    check("h_latency", done_rise, k + 2 + CPB / 2 + 9 * CPB);
    check("h_rises", rises - r0, 1);
    check("h_busy_at_done", {31'h0, busy_at_rise}, 32'h0);
    check_model("h_frame");
    pulse_ack();
    check_model("h_acked");

    // "hello" back-to-back with auto-ack
    auto_ack = 1'b1;
    got_q.delete();
    ovr_seen = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(hello[i], 1'b1);
    idle(5);
    auto_ack = 1'b0;
    check("hello_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) check($sformatf("hello_byte%0d", i), {24'h0, got_q[i]}, {24'h0, hello[i]});
    end
    check("hello_no_ovr", {31'h0, ovr_seen}, 32'h0);
    exp_d = 8'h6F;
    check_model("hello_end");

    // Overrun: second byte dropped while first not acked
    send_byte(8'h41, 1'b1);
    model_frame(8'h41, 1'b1);
    idle(3);
    send_byte(8'h42, 1'b1);
    model_frame(8'h42, 1'b1);
    check_model("overrun");
    pulse_ack();
    check_model("overrun_acked");

    // Short glitch in idle
    r0 = rises;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", {31'h0, busy}, 32'h1);
    repeat (20) @(negedge clk);
    check("glitch_idle", {31'h0, busy}, 32'h0);
    check("glitch_rises", rises - r0, 0);
    check_model("glitch");

    // Framing error followed by a held-low line
    r0 = rises;
    send_byte(8'h55, 1'b0);
    model_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    check("break_busy", {31'h0, busy}, 32'h1);
    check_model("ferr_break");
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("break_idle", {31'h0, busy}, 32'h0);
    check("break_rises", rises - r0, 0);
    check_model("ferr_idle");

    // Reset during data bit 3, then a clean frame
    a5 = 8'hA5;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = a5[i];
      repeat (CPB) @(negedge clk);
    end
    rx = a5[3];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_d = 8'h00; exp_done = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check_model("midrst");
    rst = 1'b0;
    r0 = rises;
    idle(2 * CPB);
    check("midrst_no_frame", rises - r0, 0);
    send_byte(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    check_model("after_rst_a5");
    pulse_ack();

    // Randomized frames, gaps, framing errors and acks
    for (int i = 0; i < 10; i++) begin
      idle($urandom_range(0, 5));
      b = 8'($urandom);
      err = ($urandom_range(0, 4) == 0);
      send_byte(b, !err);
      model_frame(b, !err);
      if (err) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        rx = 1'b1;
      end
      repeat (3) @(negedge clk);
      check_model($sformatf("rand%0d_%02h", i, b));
      if ($urandom_range(0, 1) == 1) pulse_ack();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
